// File: rtl/pixel_readout_if.sv
// Controller/stream bundle for the 2x2 pixel readout block.
// master = controller + downstream sink, slave = pixel_readout.
interface pixel_readout_if #(
   parameter int PIX_W = 4
);
   logic             erase;
   logic             expose;
   logic             nre_1;
   logic             nre_2;
   logic             adc;
   logic [PIX_W-1:0] adc_col1;
   logic [PIX_W-1:0] adc_col2;
   logic             pix_ready;

   logic             pix_valid;
   logic [PIX_W-1:0] pix_data;
   logic [1:0]       pix_addr;
   logic             frame_done;
   logic             busy;
   logic [4:0]       exp_count;
   logic             err_proto;
   logic             err_overrun;

   modport master (
      output erase, expose, nre_1, nre_2, adc, adc_col1, adc_col2, pix_ready,
      input  pix_valid, pix_data, pix_addr, frame_done, busy, exp_count,
             err_proto, err_overrun
   );

   modport slave (
      input  erase, expose, nre_1, nre_2, adc, adc_col1, adc_col2, pix_ready,
      output pix_valid, pix_data, pix_addr, frame_done, busy, exp_count,
             err_proto, err_overrun
   );
endinterface

// File: rtl/pixel_readout.sv
// 2x2 pixel readout: expose timer, two-row ADC capture on adc rising edge,
// then a valid/ready stream of the four pixels.
module pixel_readout #(
   parameter int PIX_W = 4
) (
   input logic             clk,
   input logic             reset,
   pixel_readout_if.slave  bus
);

   typedef enum logic [2:0] {
      S_IDLE, S_EXPOSE, S_ROW1, S_ROW2, S_DRAIN
   } state_e;

   state_e                  state_q, state_d;
   logic [3:0][PIX_W-1:0]   pix_q, pix_d;
   logic [1:0]              addr_q, addr_d;
   logic [4:0]              exp_q, exp_d;
   logic                    adc_q;
   logic                    done_q, done_d;
   logic                    errp_q, errp_d;
   logic                    erro_q, erro_d;
   logic                    rise;
   logic                    xfer;

   assign rise = bus.adc & ~adc_q;
   assign xfer = (state_q == S_DRAIN) & bus.pix_ready;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= S_IDLE;
         pix_q   <= '0;
         addr_q  <= '0;
         exp_q   <= '0;
         adc_q   <= 1'b0;
         done_q  <= 1'b0;
         errp_q  <= 1'b0;
         erro_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pix_q   <= pix_d;
         addr_q  <= addr_d;
         exp_q   <= exp_d;
         adc_q   <= bus.adc;
         done_q  <= done_d;
         errp_q  <= errp_d;
         erro_q  <= erro_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pix_d   = pix_q;
      addr_d  = addr_q;
      exp_d   = exp_q;
      done_d  = 1'b0;
      errp_d  = errp_q;
      erro_d  = erro_q;

      if (bus.erase) begin
         // Erase wins over everything; abandoning a frame mid-readout is an overrun.
         state_d = S_IDLE;
         pix_d   = '0;
         addr_d  = '0;
         if (state_q inside {S_ROW1, S_ROW2, S_DRAIN})
            erro_d = 1'b1;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (bus.expose) begin
                  exp_d   = '0;
                  state_d = S_EXPOSE;
               end
            end
            S_EXPOSE: begin
               if (bus.expose) begin
                  if (exp_q != 5'd31)
                     exp_d = exp_q + 5'd1;
               end else begin
                  state_d = S_ROW1;
               end
            end
            S_ROW1: begin
               // Any rise with row-2 enabled is either both rows or wrong order.
               if (rise) begin
                  if (!bus.nre_1 && bus.nre_2) begin
                     pix_d[0] = bus.adc_col1;
                     pix_d[1] = bus.adc_col2;
                     state_d  = S_ROW2;
                  end else if (!bus.nre_2) begin
                     errp_d = 1'b1;
                  end
               end
            end
            S_ROW2: begin
               if (rise) begin
                  if (!bus.nre_2 && bus.nre_1) begin
                     pix_d[2] = bus.adc_col1;
                     pix_d[3] = bus.adc_col2;
                     addr_d   = '0;
                     state_d  = S_DRAIN;
                  end else if (!bus.nre_1) begin
                     errp_d = 1'b1;
                  end
               end
            end
            S_DRAIN: begin
               if (xfer) begin
                  addr_d = addr_q + 2'd1;
                  if (addr_q == 2'd3) begin
                     done_d  = 1'b1;
                     state_d = S_IDLE;
                  end
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   assign bus.pix_valid   = (state_q == S_DRAIN);
   assign bus.pix_data    = pix_q[addr_q];
   assign bus.pix_addr    = addr_q;
   assign bus.frame_done  = done_q;
   assign bus.busy        = (state_q != S_IDLE);
   assign bus.exp_count   = exp_q;
   assign bus.err_proto   = errp_q;
   assign bus.err_overrun = erro_q;

endmodule
